// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// MEM wins ties; a fetch that completes while MEM is pending is parked in a one-word buffer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  IF_req_i,
    input  logic [ADDR_WIDTH-1:0] IF_addr_i,
    output logic [DATA_WIDTH-1:0] IF_rdata_o,
    output logic                  IF_valid_o,
    input  logic                  MEM_read_i,
    input  logic                  MEM_write_i,
    input  logic [ADDR_WIDTH-1:0] MEM_addr_i,
    input  logic [DATA_WIDTH-1:0] MEM_wdata_i,
    output logic [DATA_WIDTH-1:0] MEM_rdata_o,
    output logic                  MEM_valid_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic                  fetch_stall_o,
    output logic                  pipe_stall_o,
    output logic                  timeout_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StFetch, StData, StDrain} state_e;

    state_e                state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_d;
    logic                  req_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    logic mem_pend, fetch_ok;
    logic grant_data, grant_fetch;
    logic fetch_done, buf_capture, data_done, buf_deliver;

    assign mem_pend = MEM_read_i | MEM_write_i;
    assign fetch_ok = IF_req_i & ~buf_valid_q & ~flush_i;

    always_comb begin
        state_d     = state_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        fetch_done  = 1'b0;
        buf_capture = 1'b0;
        data_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_pend) begin
                    grant_data = 1'b1;
                end else if (fetch_ok) begin
                    grant_fetch = 1'b1;
                end
            end
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StIdle;
                    if (flush_i) begin
                        grant_data = mem_pend;
                    end else if (mem_pend) begin
                        buf_capture = 1'b1;
                        grant_data  = 1'b1;
                    end else begin
                        fetch_done = 1'b1;
                    end
                end else if (flush_i) begin
                    // The memory still owes a response; swallow it in StDrain.
                    state_d = StDrain;
                end
            end
            StData: begin
                if (mem_ready_i) begin
                    data_done   = 1'b1;
                    state_d     = StIdle;
                    grant_fetch = fetch_ok;
                end
            end
            StDrain: begin
                if (mem_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant_data) begin
            state_d = StData;
        end else if (grant_fetch) begin
            state_d = StFetch;
        end
    end

    always_comb begin
        req_d   = mem_req_o;
        we_d    = mem_we_o;
        addr_d  = mem_addr_o;
        wdata_d = mem_wdata_o;
        if (grant_data) begin
            req_d   = 1'b1;
            we_d    = MEM_write_i;
            addr_d  = MEM_addr_i;
            wdata_d = MEM_wdata_i;
        end else if (grant_fetch) begin
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = IF_addr_i;
        end else if (mem_req_o && mem_ready_i) begin
            req_d = 1'b0;
            we_d  = 1'b0;
        end
    end

    always_comb begin
        MEM_valid_o   = data_done;
        MEM_rdata_o   = data_done ? mem_rdata_i : '0;
        // Stalls are gated by reset so every output is quiet while reset is held.
        pipe_stall_o  = reset & mem_pend & ~data_done;
        buf_deliver   = buf_valid_q & ~pipe_stall_o & ~flush_i;
        IF_valid_o    = fetch_done | buf_deliver;
        if (fetch_done) begin
            IF_rdata_o = mem_rdata_i;
        end else if (buf_deliver) begin
            IF_rdata_o = buf_q;
        end else begin
            IF_rdata_o = '0;
        end
        fetch_stall_o = reset & IF_req_i & ~IF_valid_o;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (buf_capture) begin
            buf_valid_d = 1'b1;
            buf_d       = mem_rdata_i;
        end
        if (buf_deliver || flush_i) begin
            buf_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mem_ready_i) begin
            cnt_d = '0;
        end else if (mem_req_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_o | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            timeout_o   <= timeout_d;
        end
    end

endmodule
